// File: rtl/hls_out_bridge.sv
// ---------------------------------------------------------------------------
// hls_out_bridge
//
// Bridges an HLS ap_fifo output stream into a Xillybus 32-bit read FIFO
// port through a DEPTH-word circular buffer.
//
// Optional feature macro: HLS_OUT_EOF_EN
//   When defined, an IDLE/STREAM/DRAIN/EOF state machine drives
//   user_r_read_32_eof after hls_done once the buffer has drained.
//   When undefined, eof is tied low and hls_done is ignored.
//
// Parameters
//   DEPTH                 buffer depth in 32-bit words (power of two, 4..512)
//
// Ports
//   bus_clk               sole clock, rising edge
//   rst_n                 asynchronous active-low reset
//   out_r_din     [31:0]  HLS write data
//   out_r_write           HLS write strobe (taken when out_r_full_n=1)
//   out_r_full_n          space available to HLS (always 1 while closed)
//   hls_done              one-cycle end-of-stream pulse from HLS
//   user_r_read_32_rden   host read request
//   user_r_read_32_empty  no word available to the host
//   user_r_read_32_data   registered read data
//   user_r_read_32_eof    end of file to the host
//   user_r_read_32_open   host has the device file open
//   words_sent    [31:0]  words delivered since the last open
// ---------------------------------------------------------------------------
module hls_out_bridge #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        bus_clk,
    input  logic        rst_n,
    input  logic [31:0] out_r_din,
    input  logic        out_r_write,
    output logic        out_r_full_n,
    input  logic        hls_done,
    input  logic        user_r_read_32_rden,
    output logic        user_r_read_32_empty,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_eof,
    input  logic        user_r_read_32_open,
    output logic [31:0] words_sent
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [31:0]   rd_data_q;
    logic [31:0]   sent_q;

    logic          wr_acc;
    logic          wr_store;
    logic          rd_acc;
    logic          stream_ok;
    logic          eof_state;

    // A closed file reports space so HLS never stalls; those words are
    // swallowed because wr_store also requires open.
    assign out_r_full_n = (count < FULL_CNT) || !user_r_read_32_open;

    assign user_r_read_32_empty = (count == '0) || !user_r_read_32_open || eof_state;

    assign wr_acc   = out_r_write && out_r_full_n;
    assign wr_store = wr_acc && user_r_read_32_open && stream_ok;
    assign rd_acc   = user_r_read_32_rden && !user_r_read_32_empty;

    assign user_r_read_32_data = rd_data_q;
    assign words_sent          = sent_q;

`ifdef HLS_OUT_EOF_EN
    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        EOF
    } state_t;

    state_t state;
    logic   eof_q;

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            eof_q <= 1'b0;
        end else if (!user_r_read_32_open) begin
            state <= IDLE;
            eof_q <= 1'b0;
        end else begin
            case (state)
                // open is known high here; hls_done in IDLE is ignored
                IDLE: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (hls_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == '0 && !out_r_write) begin
                        state <= EOF;
                        eof_q <= 1'b1;
                    end
                end
                EOF: begin
                    state <= EOF;
                end
                default: begin
                    state <= IDLE;
                    eof_q <= 1'b0;
                end
            endcase
        end
    end

    // Words arriving after hls_done are accepted but not buffered.
    assign stream_ok          = (state == IDLE) || (state == STREAM);
    assign eof_state          = eof_q;
    assign user_r_read_32_eof = eof_q;
`else
    logic unused_hls_done;

    assign unused_hls_done    = hls_done;
    assign stream_ok          = 1'b1;
    assign eof_state          = 1'b0;
    assign user_r_read_32_eof = 1'b0;
`endif

    // Buffer storage carries no reset; validity is tracked by count.
    always_ff @(posedge bus_clk) begin
        if (wr_store) begin
            mem[wptr] <= out_r_din;
        end
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_data_q <= '0;
            sent_q    <= '0;
        end else if (!user_r_read_32_open) begin
            // Holding the clear while closed also covers the open falling edge.
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            sent_q <= '0;
        end else begin
            if (wr_store) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr      <= rptr + AW'(1);
                rd_data_q <= mem[rptr];
                sent_q    <= sent_q + 32'd1;
            end
            case ({wr_store, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_out_bridge.sv
module tb_hls_out_bridge;

    localparam int DEPTH = 16;

    logic        bus_clk = 1'b0;
    logic        rst_n;
    logic [31:0] out_r_din;
    logic        out_r_write;
    logic        out_r_full_n;
    logic        hls_done;
    logic        user_r_read_32_rden;
    logic        user_r_read_32_empty;
    logic [31:0] user_r_read_32_data;
    logic        user_r_read_32_eof;
    logic        user_r_read_32_open;
    logic [31:0] words_sent;

    int          n_total = 0;
    int          n_bad   = 0;

    // bench-side model
    logic [31:0] exp_q[$];
    int          m_cnt   = 0;
    logic [31:0] m_sent  = '0;
    logic [31:0] m_last  = '0;
    logic        m_drain = 1'b0;
    logic        m_eof   = 1'b0;

    hls_out_bridge #(.DEPTH(DEPTH)) u_dut (
        .bus_clk              (bus_clk),
        .rst_n                (rst_n),
        .out_r_din            (out_r_din),
        .out_r_write          (out_r_write),
        .out_r_full_n         (out_r_full_n),
        .hls_done             (hls_done),
        .user_r_read_32_rden  (user_r_read_32_rden),
        .user_r_read_32_empty (user_r_read_32_empty),
        .user_r_read_32_data  (user_r_read_32_data),
        .user_r_read_32_eof   (user_r_read_32_eof),
        .user_r_read_32_open  (user_r_read_32_open),
        .words_sent           (words_sent)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_cnt   = 0;
        m_sent  = '0;
        m_drain = 1'b0;
    endtask

    // One clock: check flags, drive inputs, advance the model, check results.
    task automatic step(input logic wr, input logic [31:0] din, input logic rd, input logic done);
        logic        wacc;
        logic        racc;
        logic        store;
        logic [31:0] exp;
        check("full_n", 32'(out_r_full_n), 32'((m_cnt < DEPTH) || !user_r_read_32_open));
        check("empty", 32'(user_r_read_32_empty), 32'((m_cnt == 0) || !user_r_read_32_open || m_eof));
        wacc  = wr && ((m_cnt < DEPTH) || !user_r_read_32_open);
        racc  = rd && (m_cnt != 0) && user_r_read_32_open;
        store = wacc && user_r_read_32_open && !m_drain;
        out_r_write         = wr;
        out_r_din           = din;
        user_r_read_32_rden = rd;
        hls_done            = done;
        @(posedge bus_clk);
        #1;
        out_r_write         = 1'b0;
        user_r_read_32_rden = 1'b0;
        hls_done            = 1'b0;
        if (store) begin
            exp_q.push_back(din);
            m_cnt++;
        end
        if (racc) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            m_cnt--;
            m_sent = m_sent + 32'd1;
            m_last = exp;
            check("rdata", user_r_read_32_data, exp);
        end else begin
            check("data_hold", user_r_read_32_data, m_last);
        end
        check("words_sent", words_sent, m_sent);
        check("eof", 32'(user_r_read_32_eof), 32'(m_eof));
    endtask

    task automatic set_open(input logic v);
        user_r_read_32_open = v;
        if (!v) begin
            clear_model();
            m_eof = 1'b0;
        end
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        out_r_din           = '0;
        out_r_write         = 1'b0;
        hls_done            = 1'b0;
        user_r_read_32_rden = 1'b0;
        user_r_read_32_open = 1'b0;

        // reset state
        #12;
        check("rst_empty", 32'(user_r_read_32_empty), 32'd1);
        check("rst_eof", 32'(user_r_read_32_eof), 32'd0);
        check("rst_full_n", 32'(out_r_full_n), 32'd1);
        check("rst_words_sent", words_sent, 32'd0);
        check("rst_data", user_r_read_32_data, 32'd0);
        user_r_read_32_open = 1'b1;
        #1;
        check("rst_open_empty", 32'(user_r_read_32_empty), 32'd1);
        check("rst_open_full_n", 32'(out_r_full_n), 32'd1);
        user_r_read_32_open = 1'b0;
        @(negedge bus_clk);
        rst_n = 1'b1;
        @(posedge bus_clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0);

        // basic five-word stream
        set_open(1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("basic_words_sent", words_sent, 32'd5);
        check("basic_empty", 32'(user_r_read_32_empty), 32'd1);

        // closed file swallows writes, reopen starts clean
        set_open(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0BAD_0000 + 32'(i), 1'b0, 1'b0);
        set_open(1'b1);
        check("reopen_empty", 32'(user_r_read_32_empty), 32'd1);
        check("reopen_words_sent", words_sent, 32'd0);

        // fill past DEPTH, then read/write at full, then read out and over-read
        for (int i = 1; i <= 20; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        check("full_flag", 32'(out_r_full_n), 32'd0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("full_rw_full_n", 32'(out_r_full_n), 32'd1);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_CAFE, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < DEPTH + 4 && m_cnt > 0; i++) step(1'b0, '0, 1'b1, 1'b0);

`ifdef HLS_OUT_EOF_EN
        // end-of-stream flow
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0E0F_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        m_drain = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        m_eof = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h5555_5555, 1'b1, 1'b0);
        set_open(1'b0);
        // hls_done while IDLE must not start a drain
        user_r_read_32_open = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0077, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
`else
        // hls_done has no effect on the stream or eof
        step(1'b1, 32'h0000_0077, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0078, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        // reset mid-stream
        for (int i = 0; i < 10; i++) step(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(user_r_read_32_empty), 32'd1);
        check("mid_rst_words_sent", words_sent, 32'd0);
        check("mid_rst_data", user_r_read_32_data, 32'd0);
        #2;
        rst_n = 1'b1;
        clear_model();
        m_eof  = 1'b0;
        m_last = '0;
        step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_data", user_r_read_32_data, 32'hA5A5_A5A5);
        check("post_rst_words_sent", words_sent, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hls_out_bridge.md
HLS_OUT_BRIDGE -- requirements
Module: hls_out_bridge

Interface
REQ-001 Parameter DEPTH, default 16, internal buffer depth in 32-bit words; power of two, 4..512.
REQ-002 bus_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 out_r_din  input  32  HLS ap_fifo output data.
REQ-005 out_r_write  input  1  HLS write strobe; the word is taken when out_r_write=1 and out_r_full_n=1.
REQ-006 out_r_full_n  output  1  space available to HLS.
REQ-007 hls_done  input  1  single-cycle pulse from HLS ap_done; marks end of stream.
REQ-008 user_r_read_32_rden  input  1  Xillybus read request.
REQ-009 user_r_read_32_empty  output  1  no word available.
REQ-010 user_r_read_32_data  output  32  registered read data.
REQ-011 user_r_read_32_eof  output  1  end of file to host.
REQ-012 user_r_read_32_open  input  1  host has the device file open.
REQ-013 words_sent  output  32  count of words delivered since the last open.

Function
REQ-014 The internal circular buffer SHALL hold DEPTH words, with write/read pointers of log2(DEPTH) bits that wrap modulo DEPTH and an occupancy count of log2(DEPTH)+1 bits.
REQ-015 out_r_full_n SHALL be 1 when occupancy<DEPTH or when open=0, and 0 otherwise; it is combinational from the registered count and open.
REQ-016 While open=0, writes SHALL be accepted and discarded, so that HLS never stalls on a closed file.
REQ-017 user_r_read_32_empty SHALL be 1 when occupancy=0 or open=0.
REQ-018 A read SHALL be accepted when rden=1 and empty=0; user_r_read_32_data then updates one cycle later with the oldest word, and is held otherwise.
REQ-019 A rden while empty=1 SHALL be ignored: no pointer, count or data change.
REQ-020 A simultaneous accepted read and write SHALL leave occupancy unchanged; this is legal at any occupancy, including 0 with a write, and DEPTH with full_n=0 meaning no write is accepted.
REQ-021 Data SHALL leave in exact write order, bit-exact, with no loss or duplication.
REQ-022 words_sent SHALL increment by 1 per accepted read and wrap at 2^32.
REQ-023 An open falling edge (open 1->0) SHALL synchronously clear pointers, occupancy, words_sent and state within one cycle.

Reset
REQ-024 Asserting rst_n=0 SHALL asynchronously clear pointers, occupancy, words_sent, user_r_read_32_data (to 0) and state (to IDLE).
REQ-025 Output values in reset: empty=1, eof=0, full_n follows REQ-015, words_sent=0.
REQ-026 Reset asserted mid-stream SHALL discard all buffered words; the first read after release returns only words written after release.

Configuration
REQ-027 Macro HLS_OUT_EOF_EN defined: an FSM of IDLE, STREAM, DRAIN and EOF SHALL control eof, with these transitions:
- IDLE->STREAM on open=1.
- STREAM->DRAIN on hls_done.
- DRAIN->EOF when occupancy=0 and no write is pending.
- Any state->IDLE on open=0.
REQ-028 With the macro defined, eof SHALL be 1 only in EOF (empty is also 1 there); writes arriving in DRAIN or EOF are accepted and discarded.
REQ-029 With the macro defined, hls_done while in IDLE SHALL be ignored.
REQ-030 Macro undefined: no FSM; eof is tied 0, hls_done is unused, and all other behaviour is identical.

Verification
REQ-031 Open=1, write 0x00000001..0x00000005, then rden on 5 cycles -> data sequence 1..5, each one cycle after its rden; empty=1 after the 5th; words_sent=5.
REQ-032 DEPTH=16, open=1, no reads, write 20 words -> full_n=0 after the 16th, words 17-20 held off; then 16 reads return words 1..16 in order.
REQ-033 At occupancy=16, rden and out_r_write in the same cycle -> the write is refused and occupancy becomes 15; at occupancy=0, rden=1 -> data unchanged and no count change.
REQ-034 Open=0, write 8 words -> full_n stays 1 and empty stays 1; then open=1 -> empty=1 and words_sent=0.
REQ-035 With HLS_OUT_EOF_EN: write 3 words, pulse hls_done, read 3 -> eof=1 the cycle after occupancy reaches 0; open=0 -> eof=0 next cycle.
REQ-036 Write 10 words, pulse rst_n=0 after 4 reads, release, write 0xA5A5A5A5, read -> returns 0xA5A5A5A5 and words_sent=1.
